priority_encoder_pipe: RTL and testbench
========================================

PRIORITY_ENCODER_PIPE -- requirements
Module: priority_encoder_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8: number of request lines; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter MODE, default 0: 0 = fixed priority with the highest index winning; 1 = round-robin.
REQ-003 The block SHALL derive localparam W = $clog2(N) as the index width; W is not overridable.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: req holds a sample to encode.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-008 The block SHALL have port req, input, N bits: request vector, with bit i as request i.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output fields hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_idx, output, W bits: index of the winning request.
REQ-012 The block SHALL have port out_none, output, 1 bit: the sampled req was all zero.

Function
REQ-013 The block SHALL perform an input transfer when in_valid and in_ready are both high at a rising clk edge, and an output transfer when out_valid and out_ready are both high.
REQ-014 The block SHALL drive in_ready = !out_valid || out_ready (combinational), so a simultaneous output and input transfer sustains one result per cycle.
REQ-015 The block SHALL present the result of an input transfer on out_valid/out_idx/out_none in the next cycle: latency 1 cycle, throughput 1 per cycle.
REQ-016 The block SHALL hold out_idx and out_none stable while out_valid=1 and out_ready=0.
REQ-017 The block SHALL clear out_valid after an output transfer with no simultaneous input transfer.
REQ-018 In MODE 0, the block SHALL set out_idx to the highest set bit of req (the generalised 4-to-2 OR equations: bit k of idx is the OR over winning positions).
REQ-019 In MODE 1, the block SHALL keep a W-bit pointer ptr and search ascending from ptr, wrapping N-1 to 0; the first set bit wins.
REQ-020 In MODE 1, the block SHALL set ptr to (winning idx + 1) mod N on each input transfer with nonzero req, and leave it unchanged otherwise.
REQ-021 In MODE 0, ptr SHALL not exist or SHALL be a constant 0.
REQ-022 For req all zero, the block SHALL produce out_none=1 and out_idx=0; this is still a valid output transfer.
REQ-023 For req nonzero, the block SHALL produce out_none=0.
REQ-024 When in_valid=0, the block SHALL leave outputs and ptr unchanged apart from the out_valid clearing of REQ-017.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force out_valid=0, out_idx=0, out_none=0 and ptr=0.
REQ-026 The block SHALL drop any in-flight result at reset assertion mid-operation; no partial output may appear.
REQ-027 The block SHALL, on the first clk edge after deassertion, accept input and drive in_ready=1.

Structure
REQ-028 The block SHALL take mode constants PE_MODE_FIXED=0 and PE_MODE_RR=1 from a shared package, pe_pkg.
REQ-029 The block SHALL implement the combinational search in one sub-module, pe_search, with parameters N and MODE, inputs req and ptr, and outputs idx and none.
REQ-030 The block SHALL instantiate pe_search once and hold the output register and ptr in the top module.

Verification
REQ-031 The bench SHALL cover: N=4, MODE 0, req=4'b1010 -> one cycle later out_idx=3, out_none=0; req=4'b0110 -> out_idx=2.
REQ-032 The bench SHALL cover: N=4, MODE 1, req=4'b1111 held for 5 transfers -> out_idx sequence 0,1,2,3,0.
REQ-033 The bench SHALL cover: N=8, MODE 1, ptr=6, req=8'b0000_0101 -> out_idx=0 (wrap-around), then ptr=1.
REQ-034 The bench SHALL cover: req=0 -> out_none=1 and out_idx=0, with ptr unchanged.
REQ-035 The bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output held stable, no sample lost; on release, back-to-back transfers at 1 per cycle.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-stream -> out_valid=0 immediately (asynchronous), and ptr=0 on the next result.

Source files
------------

// File: rtl/pe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_pkg : mode constants shared by the priority encoder blocks      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pe_pkg;
  localparam int PE_MODE_FIXED = 0;
  localparam int PE_MODE_RR    = 1;
endpackage
`default_nettype wire

// File: rtl/pe_search.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_search : combinational winner search, fixed or round-robin      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pe_search
  import pe_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = PE_MODE_FIXED,
  localparam int W    = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         none
);

  assign none = ~|req;

  generate
    if (MODE == PE_MODE_RR) begin : g_rr
      // Scan offsets from far to near so the closest set bit at or after ptr wins;
      // W-bit addition wraps N-1 back to 0 because N is a power of two.
      always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
          if (req[ptr + W'(k)]) idx = ptr + W'(k);
        end
      end
    end else begin : g_fixed
      logic unused_ptr;
      assign unused_ptr = ^ptr;

      always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i]) idx = W'(i);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/priority_encoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | priority_encoder_pipe : 1-cycle registered priority encoder        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module priority_encoder_pipe
  import pe_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = PE_MODE_FIXED,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_none_q,  out_none_d;
  logic [W-1:0] ptr_q,       ptr_d;
  logic [W-1:0] w_idx;
  logic         w_none;
  logic         w_in_xfer;

  pe_search #(
    .N    (N),
    .MODE (MODE)
  ) u_search (
    .req  (req),
    .ptr  (ptr_q),
    .idx  (w_idx),
    .none (w_none)
  );

  assign in_ready  = !out_valid_q || out_ready;
  assign w_in_xfer = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_none_d  = out_none_q;
    ptr_d       = ptr_q;
    if (w_in_xfer) begin
      out_valid_d = 1'b1;
      out_idx_d   = w_idx;
      out_none_d  = w_none;
      // In fixed mode ptr never leaves its reset value of zero.
      if (MODE == PE_MODE_RR && !w_none) ptr_d = w_idx + W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_none_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_none_q  <= out_none_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_none  = out_none_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_priority_encoder_pipe : four instances checked against a model  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_priority_encoder_pipe;
  import pe_pkg::*;

  localparam int NI = 4;
  // instance 0: N=4 fixed, 1: N=4 rr, 2: N=8 rr, 3: N=8 fixed
  localparam int N_OF  [NI] = '{4, 4, 8, 8};
  localparam bit RR_OF [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    req4 = '0;
  logic [7:0]    req8 = '0;
  logic [NI-1:0] in_rdy, o_v, o_n;
  logic [1:0]    idx_f4, idx_r4;
  logic [2:0]    idx_r8, idx_f8;

  int n_cmp = 0;
  int n_mis = 0;

  bit exp_v    [NI];
  bit exp_n    [NI];
  int exp_idx  [NI];
  int exp_ptr  [NI];

  always #5 clk = ~clk;

  priority_encoder_pipe #(.N(4), .MODE(PE_MODE_FIXED)) u_dut_f4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .req(req4),
    .out_valid(o_v[0]), .out_ready(out_ready), .out_idx(idx_f4), .out_none(o_n[0]));
  priority_encoder_pipe #(.N(4), .MODE(PE_MODE_RR)) u_dut_r4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .req(req4),
    .out_valid(o_v[1]), .out_ready(out_ready), .out_idx(idx_r4), .out_none(o_n[1]));
  priority_encoder_pipe #(.N(8), .MODE(PE_MODE_RR)) u_dut_r8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .req(req8),
    .out_valid(o_v[2]), .out_ready(out_ready), .out_idx(idx_r8), .out_none(o_n[2]));
  priority_encoder_pipe #(.N(8), .MODE(PE_MODE_FIXED)) u_dut_f8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[3]), .req(req8),
    .out_valid(o_v[3]), .out_ready(out_ready), .out_idx(idx_f8), .out_none(o_n[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_win(input int n, input bit rr, input int p, input int r);
    int q[$];
    int v;
    int h;
    if (r == 0) return 0;
    if (!rr) begin
      v = r;
      h = 0;
      while (v > 1) begin
        v = v / 2;
        h++;
      end
      return h;
    end
    for (int i = 0; i < n; i++) if (((r >> i) & 1) == 1) q.push_back(i);
    foreach (q[k]) if (q[k] >= p) return q[k];
    return q[0];
  endfunction

  function automatic int req_of(input int i);
    return (i < 2) ? int'(req4) : int'(req8);
  endfunction

  function automatic int idx_of(input int i);
    case (i)
      0:       return int'(idx_f4);
      1:       return int'(idx_r4);
      2:       return int'(idx_r8);
      default: return int'(idx_f8);
    endcase
  endfunction

  task automatic model_edge();
    int r;
    for (int i = 0; i < NI; i++) begin
      if (in_valid && (!exp_v[i] || out_ready)) begin
        r          = req_of(i);
        exp_v[i]   = 1'b1;
        exp_n[i]   = (r == 0);
        exp_idx[i] = ref_win(N_OF[i], RR_OF[i], exp_ptr[i], r);
        if (RR_OF[i] && r != 0) exp_ptr[i] = (exp_idx[i] + 1) % N_OF[i];
      end else if (out_ready) begin
        exp_v[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("out_valid[%0d]", i), o_v[i], exp_v[i]);
      chk($sformatf("out_idx[%0d]", i), idx_of(i), exp_idx[i]);
      chk($sformatf("out_none[%0d]", i), o_n[i], exp_n[i]);
    end
  endtask

  // Called at a falling edge: drive, check in_ready, advance one clock.
  task automatic cycle(input bit iv, input logic [3:0] r4, input logic [7:0] r8, input bit ordy);
    in_valid  = iv;
    req4      = r4;
    req8      = r8;
    out_ready = ordy;
    #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("in_ready[%0d]", i), in_rdy[i], !exp_v[i] || ordy);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_v[i] = 1'b0; exp_n[i] = 1'b0; exp_idx[i] = 0; exp_ptr[i] = 0;
    end
    check_outs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // round-robin with all requests: 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1, 4'b1111, 8'h00, 1'b1);
      chk($sformatf("rr4_seq%0d", t), idx_r4, t % 4);
    end

    cycle(1'b1, 4'b1010, 8'h00, 1'b1);
    chk("fix4_1010_idx", idx_f4, 3);
    chk("fix4_1010_none", o_n[0], 0);
    cycle(1'b1, 4'b0110, 8'h00, 1'b1);
    chk("fix4_0110_idx", idx_f4, 2);

    // drive rr8 pointer to 6, then exercise wrap-around
    cycle(1'b1, 4'b0001, 8'b0010_0000, 1'b1);
    chk("rr8_ptr6_setup", idx_r8, 5);
    cycle(1'b1, 4'b0001, 8'b0000_0101, 1'b1);
    chk("rr8_wrap_idx", idx_r8, 0);
    // all-zero request: none flagged, pointer stays at 1
    cycle(1'b1, 4'b0000, 8'b0000_0000, 1'b1);
    chk("zero_none", o_n[2], 1);
    chk("zero_idx", idx_r8, 0);
    cycle(1'b1, 4'b0001, 8'b0000_0011, 1'b1);
    chk("rr8_ptr1_idx", idx_r8, 1);

    // backpressure: 3 stalled cycles, then back-to-back
    cycle(1'b1, 4'b0100, 8'h80, 1'b1);
    for (int t = 0; t < 3; t++) begin
      cycle(1'b1, 4'b0001, 8'h01, 1'b0);
      chk("stall_in_ready", in_rdy[0], 0);
      chk("stall_hold_idx", idx_f4, 2);
    end
    cycle(1'b1, 4'b0010, 8'h02, 1'b1);
    cycle(1'b1, 4'b1000, 8'h10, 1'b1);
    cycle(1'b1, 4'b0011, 8'h30, 1'b1);
    cycle(1'b0, 4'b0000, 8'h00, 1'b1);

    // reset mid-stream, pointers return to zero
    cycle(1'b1, 4'b0010, 8'h04, 1'b0);
    do_reset();
    cycle(1'b1, 4'b1111, 8'hff, 1'b1);
    chk("post_reset_rr4", idx_r4, 0);
    chk("post_reset_rr8", idx_r8, 0);

    for (int c = 0; c < 300; c++) begin
      logic [3:0] r4;
      logic [7:0] r8;
      r4 = 4'($urandom);
      r8 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r4 = '0;
      if ($urandom_range(0, 7) == 0) r8 = '0;
      if (c == 150) do_reset();
      cycle($urandom_range(0, 3) != 0, r4, r8, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
